// File: rtl/wb_arbiter.sv
// Two-master to one-target Wishbone classic arbiter with round-robin grant held for the whole cyc.
// Optional forced termination of stalled transfers is enabled with `define WB_ARB_TIMEOUT_EN.
module wb_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int SEL_W          = DATA_W / 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter     TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic              io_wbs_clk,
  input  logic              io_wbs_rst,
  input  logic [ADDR_W-1:0] io_wbs_adr_m0,
  input  logic [DATA_W-1:0] io_wbs_datwr_m0,
  output logic [DATA_W-1:0] io_wbs_datrd_m0,
  input  logic              io_wbs_we_m0,
  input  logic [SEL_W-1:0]  io_wbs_sel_m0,
  input  logic              io_wbs_stb_m0,
  input  logic              io_wbs_cyc_m0,
  output logic              io_wbs_ack_m0,
  input  logic [ADDR_W-1:0] io_wbs_adr_m1,
  input  logic [DATA_W-1:0] io_wbs_datwr_m1,
  output logic [DATA_W-1:0] io_wbs_datrd_m1,
  input  logic              io_wbs_we_m1,
  input  logic [SEL_W-1:0]  io_wbs_sel_m1,
  input  logic              io_wbs_stb_m1,
  input  logic              io_wbs_cyc_m1,
  output logic              io_wbs_ack_m1,
`ifdef WB_ARB_TIMEOUT_EN
  output logic              io_timeout,
`endif
  output logic [ADDR_W-1:0] io_wbs_adr,
  output logic [DATA_W-1:0] io_wbs_datwr,
  output logic              io_wbs_we,
  output logic [SEL_W-1:0]  io_wbs_sel,
  output logic              io_wbs_stb,
  output logic              io_wbs_cyc,
  input  logic [DATA_W-1:0] io_wbs_datrd,
  input  logic              io_wbs_ack
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 ||
      $bits(TIMEOUT_DATA) > DATA_W || SEL_W != DATA_W / 8) begin : g_bad_param
    $error("wb_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state, state_nxt;
  logic   last_gnt, last_gnt_nxt;
  logic   gnt_stb;
  logic   tmo;

  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // On contention the master that did not hold the previous grant wins.
  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    case (state)
      IDLE: begin
        if (io_wbs_cyc_m0 && (!io_wbs_cyc_m1 || last_gnt)) begin
          state_nxt    = GNT0;
          last_gnt_nxt = 1'b0;
        end else if (io_wbs_cyc_m1) begin
          state_nxt    = GNT1;
          last_gnt_nxt = 1'b1;
        end
      end
      GNT0:    if (!io_wbs_cyc_m0) state_nxt = IDLE;
      GNT1:    if (!io_wbs_cyc_m1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_stb = 1'b0;
    if (state == GNT0) gnt_stb = io_wbs_stb_m0;
    if (state == GNT1) gnt_stb = io_wbs_stb_m1;
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(TIMEOUT_DATA);

  logic [CNT_W-1:0] tmo_cnt;
  logic             stall;

  // tmo_cnt holds the stalled cycles already seen; the current one makes the count reach the limit.
  assign stall      = gnt_stb && !io_wbs_ack;
  assign tmo        = stall && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign io_timeout = tmo;

  always_ff @(posedge io_wbs_clk) begin
    if (io_wbs_rst || !stall || tmo) tmo_cnt <= '0;
    else                             tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  localparam logic [DATA_W-1:0] TMO_DATA = '0;

  assign tmo = 1'b0;
`endif

  always_comb begin
    io_wbs_adr      = '0;
    io_wbs_datwr    = '0;
    io_wbs_we       = 1'b0;
    io_wbs_sel      = '0;
    io_wbs_stb      = 1'b0;
    io_wbs_cyc      = 1'b0;
    io_wbs_ack_m0   = 1'b0;
    io_wbs_ack_m1   = 1'b0;
    io_wbs_datrd_m0 = '0;
    io_wbs_datrd_m1 = '0;
    case (state)
      GNT0: begin
        io_wbs_adr      = io_wbs_adr_m0;
        io_wbs_datwr    = io_wbs_datwr_m0;
        io_wbs_we       = io_wbs_we_m0;
        io_wbs_sel      = io_wbs_sel_m0;
        io_wbs_stb      = io_wbs_stb_m0 && !tmo;
        io_wbs_cyc      = io_wbs_cyc_m0 && !tmo;
        io_wbs_ack_m0   = io_wbs_ack || tmo;
        io_wbs_datrd_m0 = tmo ? TMO_DATA : io_wbs_datrd;
      end
      GNT1: begin
        io_wbs_adr      = io_wbs_adr_m1;
        io_wbs_datwr    = io_wbs_datwr_m1;
        io_wbs_we       = io_wbs_we_m1;
        io_wbs_sel      = io_wbs_sel_m1;
        io_wbs_stb      = io_wbs_stb_m1 && !tmo;
        io_wbs_cyc      = io_wbs_cyc_m1 && !tmo;
        io_wbs_ack_m1   = io_wbs_ack || tmo;
        io_wbs_datrd_m1 = tmo ? TMO_DATA : io_wbs_datrd;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic checked every cycle against
// a grant-ownership model; the forced-termination scenario runs when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter;

  localparam int TB_TMO = 4;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] adr_m0, datwr_m0, adr_m1, datwr_m1, t_datrd;
  logic [3:0]  sel_m0, sel_m1;
  logic        we_m0, stb_m0, cyc_m0, we_m1, stb_m1, cyc_m1, t_ack;
  wire  [31:0] datrd_m0, datrd_m1, t_adr, t_datwr;
  wire  [3:0]  t_sel;
  wire         ack_m0, ack_m1, t_we, t_stb, t_cyc;
`ifdef WB_ARB_TIMEOUT_EN
  wire         timeout;
`else
  wire         timeout = 1'b0;
`endif

  wb_arbiter #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .io_wbs_clk(clk), .io_wbs_rst(rst),
    .io_wbs_adr_m0(adr_m0), .io_wbs_datwr_m0(datwr_m0), .io_wbs_datrd_m0(datrd_m0),
    .io_wbs_we_m0(we_m0), .io_wbs_sel_m0(sel_m0), .io_wbs_stb_m0(stb_m0),
    .io_wbs_cyc_m0(cyc_m0), .io_wbs_ack_m0(ack_m0),
    .io_wbs_adr_m1(adr_m1), .io_wbs_datwr_m1(datwr_m1), .io_wbs_datrd_m1(datrd_m1),
    .io_wbs_we_m1(we_m1), .io_wbs_sel_m1(sel_m1), .io_wbs_stb_m1(stb_m1),
    .io_wbs_cyc_m1(cyc_m1), .io_wbs_ack_m1(ack_m1),
`ifdef WB_ARB_TIMEOUT_EN
    .io_timeout(timeout),
`endif
    .io_wbs_adr(t_adr), .io_wbs_datwr(t_datwr), .io_wbs_we(t_we), .io_wbs_sel(t_sel),
    .io_wbs_stb(t_stb), .io_wbs_cyc(t_cyc), .io_wbs_datrd(t_datrd), .io_wbs_ack(t_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  // Model: owner is -1 when nobody holds the bus; last is the previous winner; run counts stalled cycles.
  int own = -1;
  int last = 1;
  int run = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit model_stall();
    if (own < 0) return 1'b0;
    return ((own == 0) ? stb_m0 : stb_m1) && !t_ack;
  endfunction

  function automatic bit model_fire();
    return TMO_EN && model_stall() && (run + 1 == TB_TMO);
  endfunction

  task automatic step();
    bit stall_now, fire_now;
    @(posedge clk);
    stall_now = model_stall();
    fire_now  = model_fire();
    if (rst) begin
      own = -1; last = 1; run = 0;
    end else begin
      run = (stall_now && !fire_now) ? run + 1 : 0;
      if (own < 0) begin
        if (cyc_m0 && cyc_m1) own = 1 - last;
        else if (cyc_m0)      own = 0;
        else if (cyc_m1)      own = 1;
        if (own >= 0) last = own;
      end else if (!((own == 0) ? cyc_m0 : cyc_m1)) begin
        own = -1;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    logic [31:0] e_adr, e_datwr, e_dr0, e_dr1;
    logic [3:0]  e_sel;
    logic        e_we, e_stb, e_cyc, e_ack0, e_ack1, f;
    if (mon_en) begin
      f = model_fire();
      e_adr = '0; e_datwr = '0; e_sel = '0; e_we = 0; e_stb = 0; e_cyc = 0;
      e_ack0 = 0; e_ack1 = 0; e_dr0 = '0; e_dr1 = '0;
      if (own == 0) begin
        e_adr = adr_m0; e_datwr = datwr_m0; e_sel = sel_m0; e_we = we_m0;
        e_stb = stb_m0 & ~f; e_cyc = cyc_m0 & ~f;
        e_ack0 = t_ack | f; e_dr0 = f ? 32'hDEADBEEF : t_datrd;
      end else if (own == 1) begin
        e_adr = adr_m1; e_datwr = datwr_m1; e_sel = sel_m1; e_we = we_m1;
        e_stb = stb_m1 & ~f; e_cyc = cyc_m1 & ~f;
        e_ack1 = t_ack | f; e_dr1 = f ? 32'hDEADBEEF : t_datrd;
      end
      chk("mon_adr", t_adr, e_adr);
      chk("mon_datwr", t_datwr, e_datwr);
      chk("mon_sel", t_sel, e_sel);
      chk("mon_we", t_we, e_we);
      chk("mon_stb", t_stb, e_stb);
      chk("mon_cyc", t_cyc, e_cyc);
      chk("mon_ack_m0", ack_m0, e_ack0);
      chk("mon_ack_m1", ack_m1, e_ack1);
      chk("mon_datrd_m0", datrd_m0, e_dr0);
      chk("mon_datrd_m1", datrd_m1, e_dr1);
      chk("mon_timeout", timeout, f);
    end
  end

  task automatic idle_inputs();
    cyc_m0 = 0; stb_m0 = 0; we_m0 = 0; sel_m0 = '0; adr_m0 = '0; datwr_m0 = '0;
    cyc_m1 = 0; stb_m1 = 0; we_m1 = 0; sel_m1 = '0; adr_m1 = '0; datwr_m1 = '0;
    t_ack = 0; t_datrd = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_inputs();
    step();
    mon_en = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    reset_dut();
    #1;
    chk("rst_cyc", t_cyc, 1'b0);
    chk("rst_ack_m0", ack_m0, 1'b0);

    // single write from m0
    adr_m0 = 32'h3000_0004; datwr_m0 = 32'h1234_5678; sel_m0 = 4'hF; we_m0 = 1;
    cyc_m0 = 1; stb_m0 = 1;
    #1 chk("t1_stb_c0", t_stb, 1'b0);
    step();
    #1 chk("t1_stb_c1", t_stb, 1'b1);
    chk("t1_adr_c1", t_adr, 32'h3000_0004);
    chk("t1_datwr_c1", t_datwr, 32'h1234_5678);
    step();
    step();
    t_ack = 1;
    #1 chk("t1_ack_m0_c3", ack_m0, 1'b1);
    chk("t1_ack_m1_c3", ack_m1, 1'b0);
    step();
    idle_inputs();
    step();

    // contention from reset, then round-robin
    reset_dut();
    adr_m0 = 32'h100; adr_m1 = 32'h200;
    cyc_m0 = 1; stb_m0 = 1; cyc_m1 = 1; stb_m1 = 1;
    #1 chk("t2_idle_cyc", t_cyc, 1'b0);
    step();
    #1 chk("t2_m0_first", t_adr, 32'h100);
    step();
    cyc_m0 = 0; stb_m0 = 0;
    step();
    #1 chk("t2_gap_cyc", t_cyc, 1'b0);
    step();
    #1 chk("t2_m1_next", t_adr, 32'h200);
    chk("t2_m1_cyc", t_cyc, 1'b1);
    cyc_m1 = 0; stb_m1 = 0;
    step();
    cyc_m0 = 1; stb_m0 = 1; cyc_m1 = 1; stb_m1 = 1;
    step();
    #1 chk("t2_rr_repeat", t_adr, 32'h100);
    idle_inputs();
    step();
    step();

    // m1 holds the bus for three reads while m0 waits
    adr_m0 = 32'h104; adr_m1 = 32'h300;
    cyc_m1 = 1; stb_m1 = 1; cyc_m0 = 1; stb_m0 = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      t_ack = 1; t_datrd = 32'hA1 + i;
      #1 chk("t3_datrd_m1", datrd_m1, 32'hA1 + i);
      chk("t3_datrd_m0", datrd_m0, 32'h0);
      chk("t3_ack_m0", ack_m0, 1'b0);
      step();
    end
    t_ack = 0; cyc_m1 = 0; stb_m1 = 0;
    step();
    #1 chk("t3_gap_cyc", t_cyc, 1'b0);
    step();
    #1 chk("t3_m0_after", t_adr, 32'h104);
    idle_inputs();
    step();

    // reset in the middle of an m0 transfer
    adr_m0 = 32'h108; cyc_m0 = 1; stb_m0 = 1;
    step();
    #1 chk("t4_gnt_cyc", t_cyc, 1'b1);
    rst = 1;
    step();
    rst = 0;
    #1 chk("t4_rst_cyc", t_cyc, 1'b0);
    chk("t4_rst_stb", t_stb, 1'b0);
    cyc_m0 = 0; stb_m0 = 0; t_ack = 1; t_datrd = 32'h77;
    #1 chk("t4_late_ack", ack_m0, 1'b0);
    step();
    t_ack = 0; adr_m1 = 32'h208;
    cyc_m0 = 1; stb_m0 = 1; cyc_m1 = 1; stb_m1 = 1;
    step();
    #1 chk("t4_m0_wins", t_adr, 32'h108);
    idle_inputs();
    step();
    step();

    // target ack with nobody granted
    t_ack = 1; t_datrd = 32'h55AA_55AA;
    #1 chk("t6_ack_m0", ack_m0, 1'b0);
    chk("t6_ack_m1", ack_m1, 1'b0);
    chk("t6_datrd_m0", datrd_m0, 32'h0);
    step();
    idle_inputs();

`ifdef WB_ARB_TIMEOUT_EN
    // target that never acks
    reset_dut();
    cyc_m0 = 1; stb_m0 = 1; adr_m0 = 32'h10C;
    step();
    for (int k = 1; k < TB_TMO; k++) begin
      #1 chk("t5_no_timeout", timeout, 1'b0);
      step();
    end
    #1 chk("t5_timeout", timeout, 1'b1);
    chk("t5_ack_m0", ack_m0, 1'b1);
    chk("t5_datrd_m0", datrd_m0, 32'hDEADBEEF);
    chk("t5_stb", t_stb, 1'b0);
    idle_inputs();
    step();
`endif

    // random traffic
    reset_dut();
    for (int n = 0; n < 1500; n++) begin
      cyc_m0 = cyc_m0 ^ ($urandom_range(7) == 0);
      cyc_m1 = cyc_m1 ^ ($urandom_range(7) == 0);
      stb_m0 = cyc_m0 & $urandom_range(1);
      stb_m1 = cyc_m1 & $urandom_range(1);
      we_m0 = $urandom_range(1); we_m1 = $urandom_range(1);
      adr_m0 = $urandom; adr_m1 = $urandom;
      datwr_m0 = $urandom; datwr_m1 = $urandom;
      sel_m0 = 4'($urandom_range(15)); sel_m1 = 4'($urandom_range(15));
      t_ack = ($urandom_range(2) == 0);
      t_datrd = $urandom;
      rst = ($urandom_range(63) == 0);
      step();
    end
    rst = 0;
    idle_inputs();
    step();
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Two-initiator to one-target Wishbone classic arbiter. It is the many-to-one counterpart of the address-decoding one-to-many peripheral mux. It lets two masters share one Wishbone target, such as the peripheral mux input or a single register block, using round-robin arbitration. A grant is held for the whole bus cycle (cyc).

Parameters:
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width on all ports
- SEL_W, DATA_W/8, byte-select width
- TIMEOUT_CYCLES, 255, cycles of unacknowledged stb before a forced termination (used only with WB_ARB_TIMEOUT_EN); legal range 1..65535
- TIMEOUT_DATA, 32'hDEADBEEF, read data returned on a forced termination (used only with WB_ARB_TIMEOUT_EN)

Ports:
- io_wbs_clk  in  1  single clock
- io_wbs_rst  in  1  synchronous reset, active-high
- io_wbs_adr_m0 / io_wbs_adr_m1  in  ADDR_W  master address
- io_wbs_datwr_m0 / io_wbs_datwr_m1  in  DATA_W  master write data
- io_wbs_datrd_m0 / io_wbs_datrd_m1  out  DATA_W  read data to master
- io_wbs_we_m0 / io_wbs_we_m1  in  1  write enable
- io_wbs_sel_m0 / io_wbs_sel_m1  in  SEL_W  byte select
- io_wbs_stb_m0 / io_wbs_stb_m1  in  1  strobe
- io_wbs_cyc_m0 / io_wbs_cyc_m1  in  1  cycle (bus request)
- io_wbs_ack_m0 / io_wbs_ack_m1  out  1  acknowledge to master
- io_wbs_adr / io_wbs_datwr / io_wbs_we / io_wbs_sel / io_wbs_stb / io_wbs_cyc  out  (as above)  target-side request
- io_wbs_datrd  in  DATA_W  target read data
- io_wbs_ack  in  1  target acknowledge
- io_timeout  out  1  one-cycle forced-termination pulse (present only with WB_ARB_TIMEOUT_EN)

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. Clock port is io_wbs_clk, reset port is io_wbs_rst.
- State machine: IDLE, GNT0, GNT1.
  - State register and last_gnt register (1 bit) are the only sequential state, plus the timeout counter when enabled.
- Reset values:
  - state=IDLE, last_gnt=1, so master 0 wins the first contention.
  - All target-side outputs are 0.
  - All master acks and datrd outputs are 0.
  - io_timeout is 0.
- IDLE transitions:
  - Only cyc_m0 asserted -> GNT0.
  - Only cyc_m1 asserted -> GNT1.
  - Both asserted -> the master that is not last_gnt wins.
  - last_gnt is updated on entry to a GNT state.
- GNTx transitions:
  - Stay while cyc_mx=1.
  - cyc_mx=0 -> IDLE on the next edge.
  - There is no direct GNT0->GNT1 handoff; one IDLE cycle always separates grants.
- Grant latency: a request seen in IDLE at edge N is forwarded from cycle N+1. Minimum one-cycle arbitration latency.
- Forwarding:
  - Target outputs are combinational from the registered state. In GNTx, adr/datwr/we/sel/stb/cyc equal master x's signals.
  - In IDLE, all target outputs are 0; in particular stb and cyc are 0.
- Response routing:
  - ack_mx = io_wbs_ack only in GNTx, otherwise 0.
  - datrd_mx = io_wbs_datrd in GNTx, otherwise 0.
  - The non-granted master sees ack=0 and datrd=0 at all times.
- Multiple transfers: a master may hold cyc and issue several stb/ack transfers. It keeps the grant throughout, even if the other master is requesting.
- Starvation: after master x releases, a pending master y wins the next IDLE arbitration.
- Reset mid-transfer: state goes to IDLE at the reset edge. Target cyc/stb drop the same cycle, any in-flight ack is discarded, and last_gnt returns to 1.
- Target ack while IDLE: ignored, not routed to either master.

Optional Feature:
Macro WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) increments each cycle that the granted stb=1 and io_wbs_ack=0.
  - The counter clears on ack, on stb=0, in IDLE, and on reset.
  - When the counter reaches TIMEOUT_CYCLES, that cycle: ack_mx=1, datrd_mx=TIMEOUT_DATA, io_wbs_stb and io_wbs_cyc are forced 0, and io_timeout=1.
  - The counter then clears.
- Without the macro: no counter and no io_timeout port. The arbiter waits indefinitely for the target ack.

Test Plan:
- Reset, then m0 single write: adr=0x30000004, datwr=0x12345678, sel=0xF, cyc/stb asserted at cycle 0 -> target stb rises at cycle 1; target ack at cycle 3 -> ack_m0=1 at cycle 3, ack_m1 stays 0.
- Simultaneous cyc_m0 and cyc_m1 from reset -> m0 granted first. After m0 drops cyc, one IDLE cycle, then m1 granted. Repeat the contention -> m0 wins again, confirming round-robin alternation.
- m1 holds cyc for 3 back-to-back reads (target datrd 0xA1, 0xA2, 0xA3) while m0 requests -> m1 receives all three values in order; m0 is granted only after m1 drops cyc; datrd_m0 stays 0 throughout.
- Synchronous reset asserted during an m0 transfer, before ack -> at the next edge target cyc/stb=0 and state=IDLE. An ack arriving the following cycle is not routed; after release, m0 wins the first contention.
- WB_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and a target that never acks -> on the 4th stalled cycle ack_m0=1, datrd_m0=0xDEADBEEF, io_timeout=1, target stb=0 for that cycle.
- Target asserts ack while IDLE and no request is active -> both master acks remain 0.
